keyboard_word_entry: RTL

Upstream stage of the ten-letter word register. Consumes PS/2 Set-2 scan codes from the keyboard receiver and decodes make codes to uppercase ASCII. Maintains the letter fill index and issues one-cycle `load` writes (`ascii_code`, `counter`) to the word register bank. Handles break/extended prefixes, backspace and enter, and signals completion of a word with `done`.

---
 rtl/kwe_pkg.sv | 20 ++
 rtl/scan_to_ascii.sv | 56 +++++
 rtl/keyboard_word_entry.sv | 90 +++++++++
 3 files changed

// File: rtl/kwe_pkg.sv
// kwe_pkg: shared states, word length and PS/2 Set-2 constants for keyboard_word_entry
package kwe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_LOCKED
    } kwe_state_e;

    localparam int WORD_LEN = 10;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/scan_to_ascii.sv
// scan_to_ascii: combinational Set-2 make code to uppercase ASCII lookup
// Digit codes are mapped only when KWE_DIGITS_EN is defined.
module scan_to_ascii (
    input  logic [7:0] scan_code,
    output logic [7:0] ascii,
    output logic       valid
);

    always_comb begin
        ascii = 8'h00;
        case (scan_code)
            8'h1C: ascii = "A";
            8'h32: ascii = "B";
            8'h21: ascii = "C";
            8'h23: ascii = "D";
            8'h24: ascii = "E";
            8'h2B: ascii = "F";
            8'h34: ascii = "G";
            8'h33: ascii = "H";
            8'h43: ascii = "I";
            8'h3B: ascii = "J";
            8'h42: ascii = "K";
            8'h4B: ascii = "L";
            8'h3A: ascii = "M";
            8'h31: ascii = "N";
            8'h44: ascii = "O";
            8'h4D: ascii = "P";
            8'h15: ascii = "Q";
            8'h2D: ascii = "R";
            8'h1B: ascii = "S";
            8'h2C: ascii = "T";
            8'h3C: ascii = "U";
            8'h2A: ascii = "V";
            8'h1D: ascii = "W";
            8'h22: ascii = "X";
            8'h35: ascii = "Y";
            8'h1A: ascii = "Z";
`ifdef KWE_DIGITS_EN
            8'h45: ascii = "0";
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
`endif
            default: ascii = 8'h00;
        endcase
    end

    assign valid = ascii != 8'h00;

endmodule

// File: rtl/keyboard_word_entry.sv
// keyboard_word_entry: decodes PS/2 make codes into one-cycle slot writes for a ten-letter word
// Optional digit entry is enabled by defining KWE_DIGITS_EN.
module keyboard_word_entry
    import kwe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       clear,
    output logic [7:0] ascii_code,
    output logic       load,
    output logic [3:0] counter,
    output logic       full,
    output logic       done
);

    kwe_state_e state_q;
    logic [3:0] fill_q;
    logic [7:0] ascii_q;
    logic [3:0] counter_q;
    logic       load_q;
    logic       done_q;
    logic [7:0] map_ascii;
    logic       map_valid;

    scan_to_ascii u_map (
        .scan_code (scan_code),
        .ascii     (map_ascii),
        .valid     (map_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            fill_q    <= 4'd0;
            ascii_q   <= 8'h00;
            counter_q <= 4'd0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            // clear wins over a coincident byte; stale slots are overwritten on re-entry
            if (clear) begin
                state_q <= ST_IDLE;
                fill_q  <= 4'd0;
            end else if (scan_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (scan_code == SC_BREAK) begin
                            state_q <= ST_BRK;
                        end else if (scan_code == SC_EXT) begin
                            state_q <= ST_EXT;
                        end else if (map_valid) begin
                            if (fill_q < 4'(WORD_LEN)) begin
                                load_q    <= 1'b1;
                                counter_q <= fill_q;
                                ascii_q   <= map_ascii;
                                fill_q    <= fill_q + 4'd1;
                            end
                        end else if (scan_code == SC_BKSP) begin
                            if (fill_q != 4'd0) begin
                                load_q    <= 1'b1;
                                counter_q <= fill_q - 4'd1;
                                ascii_q   <= ASCII_SPACE;
                                fill_q    <= fill_q - 4'd1;
                            end
                        end else if (scan_code == SC_ENTER && fill_q != 4'd0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_LOCKED;
                        end
                    end
                    ST_BRK:     state_q <= ST_IDLE;
                    ST_EXT:     state_q <= (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    ST_EXT_BRK: state_q <= ST_IDLE;
                    ST_LOCKED:  state_q <= ST_LOCKED;
                    default:    state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ascii_code = ascii_q;
    assign counter    = counter_q;
    assign load       = load_q;
    assign done       = done_q;
    assign full       = fill_q == 4'(WORD_LEN);

endmodule
